// File: rtl/dds_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dds_ctrl_pkg
// Shared types and constants for the DDS frequency-sweep sequencer.
//   state_t      : sequencer states (IDLE / SYNC / DWELL / DONE)
//   MODE_*       : sweep mode encodings on mode_i (3 is reserved, acts as single)
//   SWEEP_CNT_W  : width of the optional leg counter (DDS_SWEEP_CNT_EN)
//   sat_inc()    : saturating increment used by the leg counter
// ---------------------------------------------------------------------------
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

  localparam int SWEEP_CNT_W = 16;

  // Counts up but sticks at all-ones instead of wrapping.
  function automatic logic [SWEEP_CNT_W-1:0] sat_inc(input logic [SWEEP_CNT_W-1:0] value);
    return (value == '1) ? value : value + SWEEP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl_if
// Register/AXI-side control bundle of the sweep sequencer.
//   start_i, abort_i            : request strobes from the register layer
//   mode_i                      : sweep mode (see dds_ctrl_pkg MODE_*)
//   f_start_i, f_stop_i, f_step_i : sweep start / stop / step increments
//   dwell_i                     : each value is held dwell_i+1 cycles
//   busy_o, done_o              : status back to the register layer
// Modports: master = register layer, slave = sequencer.
// ---------------------------------------------------------------------------
interface dds_sweep_ctrl_if #(
  parameter int INC_BITS   = 32,
  parameter int DWELL_BITS = 16
);

  logic                  start_i;
  logic                  abort_i;
  logic [1:0]            mode_i;
  logic [INC_BITS-1:0]   f_start_i;
  logic [INC_BITS-1:0]   f_stop_i;
  logic [INC_BITS-1:0]   f_step_i;
  logic [DWELL_BITS-1:0] dwell_i;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output start_i, abort_i, mode_i, f_start_i, f_stop_i, f_step_i, dwell_i,
    input  busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, mode_i, f_start_i, f_stop_i, f_step_i, dwell_i,
    output busy_o, done_o
  );

endinterface

// File: rtl/dds_sweep_ctrl_step.sv
// ---------------------------------------------------------------------------
// dds_sweep_step
// Combinational next-increment calculator for one sweep step.
//   cur_inc   : increment currently driven to the accumulator
//   step      : unsigned step magnitude
//   target    : end value of the current leg
//   ascend    : 1 = move upwards towards target, 0 = downwards
//   next_inc  : cur_inc moved one step towards target, clamped at target
//   at_target : cur_inc already equals target
// The arithmetic is one bit wider than the increment so a carry or borrow is
// seen as "past the target" rather than wrapping around.
// ---------------------------------------------------------------------------
module dds_sweep_step #(
  parameter int INC_BITS = 32
) (
  input  logic [INC_BITS-1:0] cur_inc,
  input  logic [INC_BITS-1:0] step,
  input  logic [INC_BITS-1:0] target,
  input  logic                ascend,
  output logic [INC_BITS-1:0] next_inc,
  output logic                at_target
);

  logic [INC_BITS:0] sum;
  logic [INC_BITS:0] diff;

  always_comb begin
    sum       = {1'b0, cur_inc} + {1'b0, step};
    diff      = {1'b0, cur_inc} - {1'b0, step};
    at_target = (cur_inc == target);
    // Clamping to target is the fallback; a zero step therefore jumps
    // straight to the end of the leg instead of stalling the sweep.
    next_inc  = target;
    if (step != '0) begin
      if (ascend) begin
        if (!sum[INC_BITS] && (sum[INC_BITS-1:0] <= target)) begin
          next_inc = sum[INC_BITS-1:0];
        end
      end else begin
        if (!diff[INC_BITS] && (diff[INC_BITS-1:0] >= target)) begin
          next_inc = diff[INC_BITS-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
// Frequency-sweep sequencer feeding the DDS phase accumulator. Steps the
// phase increment from f_start to f_stop in f_step increments, holding each
// value dwell+1 cycles, in single, repeating-sawtooth or triangle mode.
//   out_clk     : DDS clock, rising edge
//   rst         : asynchronous, active-low reset
//   ctl         : register-side bundle (dds_sweep_ctrl_if.slave)
//   inc_o       : registered increment to the accumulator
//   sync_o      : one-cycle phase-reset pulse, aligned with the new inc_o
//   dir_o       : 1 = current leg ascending, 0 = descending
//   sweep_cnt_o : saturating count of completed legs (only when the macro
//                 DDS_SWEEP_CNT_EN is defined)
// ---------------------------------------------------------------------------
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int INC_BITS   = 32,
  parameter int DWELL_BITS = 16
) (
  input  logic                   out_clk,
  input  logic                   rst,
  dds_sweep_ctrl_if.slave        ctl,
  output logic [INC_BITS-1:0]    inc_o,
  output logic                   sync_o,
  output logic                   dir_o
`ifdef DDS_SWEEP_CNT_EN
  ,
  output logic [SWEEP_CNT_W-1:0] sweep_cnt_o
`endif
);

  state_t                state;
  state_t                state_next;

  // Shadow copies of the sweep set-up, captured when start is accepted so
  // the register layer may change its inputs mid-sweep.
  logic [1:0]            mode_s;
  logic [INC_BITS-1:0]   start_s;
  logic [INC_BITS-1:0]   stop_s;
  logic [INC_BITS-1:0]   step_s;
  logic [DWELL_BITS-1:0] dwell_s;

  logic [INC_BITS-1:0]   inc_q;
  logic [INC_BITS-1:0]   inc_next;
  logic [DWELL_BITS-1:0] cnt_q;
  logic [DWELL_BITS-1:0] cnt_next;
  logic                  dir_q;
  logic                  dir_next;
  // back_q marks the return leg of a triangle, whose target is start_s.
  logic                  back_q;
  logic                  back_next;
  logic                  load;
  logic                  hold_end;

  logic [INC_BITS-1:0]   leg_target;
  logic [INC_BITS-1:0]   turn_target;
  logic [INC_BITS-1:0]   fwd_next;
  logic [INC_BITS-1:0]   turn_next;
  logic                  fwd_at_target;
  logic                  turn_at_target;

  assign leg_target  = back_q ? start_s : stop_s;
  assign turn_target = back_q ? stop_s  : start_s;
  assign hold_end    = (cnt_q == '0);

  // Step along the current leg.
  dds_sweep_step #(.INC_BITS(INC_BITS)) u_step_fwd (
    .cur_inc   (inc_q),
    .step      (step_s),
    .target    (leg_target),
    .ascend    (dir_q),
    .next_inc  (fwd_next),
    .at_target (fwd_at_target)
  );

  // First step of the following triangle leg, taken in the turn cycle.
  dds_sweep_step #(.INC_BITS(INC_BITS)) u_step_turn (
    .cur_inc   (inc_q),
    .step      (step_s),
    .target    (turn_target),
    .ascend    (~dir_q),
    .next_inc  (turn_next),
    .at_target (turn_at_target)
  );

  always_ff @(posedge out_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    inc_next   = inc_q;
    cnt_next   = cnt_q;
    dir_next   = dir_q;
    back_next  = back_q;
    load       = 1'b0;

    case (state)
      IDLE: begin
        if (ctl.start_i) begin
          load       = 1'b1;
          state_next = SYNC;
          inc_next   = ctl.f_start_i;
          cnt_next   = ctl.dwell_i;
          dir_next   = (ctl.f_stop_i >= ctl.f_start_i);
          back_next  = 1'b0;
        end
      end

      // The SYNC cycle is the first cycle of the start value's hold, so it
      // runs the same dwell countdown as DWELL.
      SYNC, DWELL: begin
        state_next = DWELL;
        if (!hold_end) begin
          cnt_next = cnt_q - DWELL_BITS'(1);
        end else begin
          cnt_next = dwell_s;
          if (!fwd_at_target) begin
            inc_next = fwd_next;
          end else begin
            case (mode_s)
              MODE_REPEAT: begin
                state_next = SYNC;
                inc_next   = start_s;
              end
              MODE_TRI: begin
                inc_next  = turn_next;
                back_next = ~back_q;
                // A flat triangle (start == stop) has no direction to reverse.
                if (!turn_at_target) begin
                  dir_next = ~dir_q;
                end
              end
              MODE_SINGLE: begin
                state_next = DONE;
              end
              default: begin
                state_next = DONE;
              end
            endcase
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort beats every transition, including a simultaneous start.
    if (ctl.abort_i) begin
      state_next = IDLE;
      inc_next   = inc_q;
      cnt_next   = cnt_q;
      dir_next   = dir_q;
      back_next  = back_q;
      load       = 1'b0;
    end
  end

  always_ff @(posedge out_clk or negedge rst) begin
    if (!rst) begin
      inc_q  <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      back_q <= 1'b0;
    end else begin
      inc_q  <= inc_next;
      cnt_q  <= cnt_next;
      dir_q  <= dir_next;
      back_q <= back_next;
    end
  end

  always_ff @(posedge out_clk or negedge rst) begin
    if (!rst) begin
      mode_s  <= MODE_SINGLE;
      start_s <= '0;
      stop_s  <= '0;
      step_s  <= '0;
      dwell_s <= '0;
    end else if (load) begin
      mode_s  <= ctl.mode_i;
      start_s <= ctl.f_start_i;
      stop_s  <= ctl.f_stop_i;
      step_s  <= ctl.f_step_i;
      dwell_s <= ctl.dwell_i;
    end
  end

  assign inc_o      = inc_q;
  assign dir_o      = dir_q;
  assign sync_o     = (state == SYNC);
  assign ctl.done_o = (state == DONE);
  assign ctl.busy_o = (state == SYNC) || (state == DWELL);

`ifdef DDS_SWEEP_CNT_EN
  logic [SWEEP_CNT_W-1:0] sweep_cnt_q;
  logic                   leg_end;

  // End of any leg: single completion, repeat wrap or triangle turn.
  assign leg_end = ((state == SYNC) || (state == DWELL)) && hold_end &&
                   fwd_at_target && !ctl.abort_i;

  always_ff @(posedge out_clk or negedge rst) begin
    if (!rst) begin
      sweep_cnt_q <= '0;
    end else if (load) begin
      sweep_cnt_q <= '0;
    end else if (leg_end) begin
      sweep_cnt_q <= sat_inc(sweep_cnt_q);
    end
  end

  assign sweep_cnt_o = sweep_cnt_q;
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
// Directed bench for dds_sweep_ctrl with hand-computed expected sequences.
// Exercises the sweep counter output as well when DDS_SWEEP_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;
  import dds_ctrl_pkg::*;

  localparam int INC_BITS   = 32;
  localparam int DWELL_BITS = 16;

  logic                out_clk = 1'b0;
  logic                rst     = 1'b1;
  logic [INC_BITS-1:0] inc;
  logic                sync;
  logic                dir;
`ifdef DDS_SWEEP_CNT_EN
  logic [SWEEP_CNT_W-1:0] sweep_cnt;
`endif

  int compares = 0;
  int fails    = 0;

  int unsigned t2_inc[4]   = '{0, 10, 20, 25};
  int unsigned tri_inc[8]  = '{0, 10, 20, 10, 0, 10, 20, 10};
  bit          tri_dir[8]  = '{1, 1, 1, 0, 0, 1, 1, 0};
  int unsigned rep_inc[13] = '{5, 5, 6, 6, 7, 7, 5, 5, 6, 6, 7, 7, 5};

  dds_sweep_ctrl_if #(.INC_BITS(INC_BITS), .DWELL_BITS(DWELL_BITS)) ctl ();

  dds_sweep_ctrl #(.INC_BITS(INC_BITS), .DWELL_BITS(DWELL_BITS)) dut (
    .out_clk     (out_clk),
    .rst         (rst),
    .ctl         (ctl),
    .inc_o       (inc),
    .sync_o      (sync),
    .dir_o       (dir)
`ifdef DDS_SWEEP_CNT_EN
    ,
    .sweep_cnt_o (sweep_cnt)
`endif
  );

  always #5 out_clk = ~out_clk;

  task automatic tick();
    @(posedge out_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    compares++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_cycle(input string tag, input logic [31:0] exp_inc,
                             input logic exp_sync, input logic exp_busy,
                             input logic exp_done, input logic exp_dir);
    check_output({tag, ".inc"},  64'(inc),        64'(exp_inc));
    check_output({tag, ".sync"}, 64'(sync),       64'(exp_sync));
    check_output({tag, ".busy"}, 64'(ctl.busy_o), 64'(exp_busy));
    check_output({tag, ".done"}, 64'(ctl.done_o), 64'(exp_done));
    check_output({tag, ".dir"},  64'(dir),        64'(exp_dir));
  endtask

  task automatic apply_stimulus(input logic [1:0] mode, input logic [31:0] f_start,
                                input logic [31:0] f_stop, input logic [31:0] f_step,
                                input logic [15:0] dwell);
    ctl.mode_i    = mode;
    ctl.f_start_i = f_start;
    ctl.f_stop_i  = f_stop;
    ctl.f_step_i  = f_step;
    ctl.dwell_i   = dwell;
    ctl.start_i   = 1'b1;
    tick();
    ctl.start_i   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ctl.start_i   = 1'b0;
    ctl.abort_i   = 1'b0;
    ctl.mode_i    = 2'd0;
    ctl.f_start_i = '0;
    ctl.f_stop_i  = '0;
    ctl.f_step_i  = '0;
    ctl.dwell_i   = '0;

    // Reset
    #2 rst = 1'b0;
    #2;
    check_cycle("reset", 0, 0, 0, 0, 0);
`ifdef DDS_SWEEP_CNT_EN
    check_output("reset.cnt", 64'(sweep_cnt), 64'd0);
`endif
    #8 rst = 1'b1;
    tick();
    check_cycle("idle", 0, 0, 0, 0, 0);

    // 1: single ascending sweep, dwell 2
    apply_stimulus(MODE_SINGLE, 100, 130, 10, 2);
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 3; k++) begin
        check_cycle($sformatf("t1.v%0d.c%0d", v, k), 32'(100 + 10 * v),
                    (v == 0) && (k == 0), 1'b1, 1'b0, 1'b1);
        tick();
      end
    end
    check_cycle("t1.done", 130, 0, 0, 1, 1);
`ifdef DDS_SWEEP_CNT_EN
    check_output("t1.cnt", 64'(sweep_cnt), 64'd1);
`endif
    tick();
    check_cycle("t1.idle", 130, 0, 0, 0, 1);

    // 2a: clamp to stop
    apply_stimulus(MODE_SINGLE, 0, 25, 10, 0);
    for (int i = 0; i < 4; i++) begin
      check_cycle($sformatf("t2a.%0d", i), t2_inc[i], i == 0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    check_cycle("t2a.done", 25, 0, 0, 1, 1);
    tick();

    // 2b: carry out of the top bit must clamp, never wrap
    apply_stimulus(MODE_SINGLE, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0);
    check_cycle("t2b.0", 32'hFFFF_FFF0, 1, 1, 0, 1);
    tick();
    check_cycle("t2b.1", 32'hFFFF_FFFF, 0, 1, 0, 1);
    tick();
    check_cycle("t2b.done", 32'hFFFF_FFFF, 0, 0, 1, 1);
    tick();

    // 3a: triangle, then abort
    apply_stimulus(MODE_TRI, 0, 20, 10, 0);
    for (int i = 0; i < 8; i++) begin
      check_cycle($sformatf("t3a.%0d", i), tri_inc[i], i == 0, 1'b1, 1'b0, tri_dir[i]);
      tick();
    end
    ctl.abort_i = 1'b1;
    tick();
    ctl.abort_i = 1'b0;
    check_cycle("t3a.abort", 0, 0, 0, 0, 0);
`ifdef DDS_SWEEP_CNT_EN
    check_output("t3a.cnt", 64'(sweep_cnt), 64'd3);
`endif

    // 3b: single descending sweep with clamp
    apply_stimulus(MODE_SINGLE, 50, 20, 20, 0);
    check_cycle("t3b.0", 50, 1, 1, 0, 0);
    tick();
    check_cycle("t3b.1", 30, 0, 1, 0, 0);
    tick();
    check_cycle("t3b.2", 20, 0, 1, 0, 0);
    tick();
    check_cycle("t3b.done", 20, 0, 0, 1, 0);
`ifdef DDS_SWEEP_CNT_EN
    check_output("t3b.cnt", 64'(sweep_cnt), 64'd1);
`endif
    tick();

    // 4: repeating sawtooth, sync every 6 cycles
    apply_stimulus(MODE_REPEAT, 5, 7, 1, 1);
    for (int i = 0; i < 13; i++) begin
      check_cycle($sformatf("t4.%0d", i), rep_inc[i], (i % 6) == 0, 1'b1, 1'b0, 1'b1);
`ifdef DDS_SWEEP_CNT_EN
      check_output($sformatf("t4.cnt%0d", i), 64'(sweep_cnt), 64'(i / 6));
`endif
      tick();
    end
    ctl.abort_i = 1'b1;
    tick();
    ctl.abort_i = 1'b0;
    check_cycle("t4.abort", 5, 0, 0, 0, 1);

    // 5a: abort mid-dwell at 110
    apply_stimulus(MODE_SINGLE, 100, 130, 10, 2);
    tick();
    tick();
    tick();
    check_cycle("t5a.pre", 110, 0, 1, 0, 1);
    ctl.abort_i = 1'b1;
    tick();
    ctl.abort_i = 1'b0;
    check_cycle("t5a.abort", 110, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_cycle($sformatf("t5a.after%0d", i), 110, 0, 0, 0, 1);
    end

    // 5b: start and abort together
    ctl.f_start_i = 777;
    ctl.start_i   = 1'b1;
    ctl.abort_i   = 1'b1;
    tick();
    ctl.start_i   = 1'b0;
    ctl.abort_i   = 1'b0;
    check_cycle("t5b.0", 110, 0, 0, 0, 1);
    tick();
    check_cycle("t5b.1", 110, 0, 0, 0, 1);

    // 5c: asynchronous reset mid-sweep
    apply_stimulus(MODE_SINGLE, 100, 130, 10, 2);
    tick();
    tick();
    check_cycle("t5c.pre", 100, 0, 1, 0, 1);
    #2 rst = 1'b0;
    #1;
    check_cycle("t5c.rst", 0, 0, 0, 0, 0);
`ifdef DDS_SWEEP_CNT_EN
    check_output("t5c.cnt", 64'(sweep_cnt), 64'd0);
`endif
    #1 rst = 1'b1;
    tick();
    check_cycle("t5c.idle", 0, 0, 0, 0, 0);

    // 6: zero step jumps to stop; start pulses while busy are ignored
    apply_stimulus(MODE_SINGLE, 10, 40, 0, 2);
    for (int i = 0; i < 6; i++) begin
      check_cycle($sformatf("t6.%0d", i), (i < 3) ? 32'd10 : 32'd40, i == 0,
                  1'b1, 1'b0, 1'b1);
      if (i == 1) begin
        ctl.start_i   = 1'b1;
        ctl.f_start_i = 999;
        ctl.mode_i    = MODE_TRI;
      end
      if (i == 2) begin
        ctl.start_i = 1'b0;
      end
      tick();
    end
    check_cycle("t6.done", 40, 0, 0, 1, 1);
    tick();
    check_cycle("t6.idle", 40, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
